// File: rtl/seq_sipo_byte_framer_if.sv
// Bus between the serial byte framer and its neighbours: the serial bit stream
// in, the byte val/rdy stream out and the sticky status flags.
interface seq_sipo_byte_framer_if;
  logic       en;
  logic       sin;
  logic       sync;
  // out_byte transfers on a rising edge where out_val && out_rdy; out_val never
  // depends on out_rdy, and out_val/out_byte hold steady until that transfer.
  logic       out_val;
  logic       out_rdy;
  logic [7:0] out_byte;
  logic       overflow;
  logic       perr;

  modport master (
    output en, sin, sync, out_rdy,
    input  out_val, out_byte, overflow, perr
  );

  modport slave (
    input  en, sin, sync, out_rdy,
    output out_val, out_byte, overflow, perr
  );
endinterface

// File: rtl/seq_sipo_byte_framer.sv
// Serial-to-byte framer with sync realignment and a 2-entry output FIFO.
// Optional odd-parity frame check enabled by defining SEQ_SIPO_BYTE_FRAMER_PARITY_EN.
module seq_sipo_byte_framer (
  input  logic                    clk,
  input  logic                    reset,
  seq_sipo_byte_framer_if.slave   bus
);

`ifdef SEQ_SIPO_BYTE_FRAMER_PARITY_EN
  localparam logic [3:0] LAST = 4'd8;
  localparam int         SR_W = 8;
`else
  // Without parity the oldest bit shifts straight into the byte, so only 7 bits need storing.
  localparam logic [3:0] LAST = 4'd7;
  localparam int         SR_W = 7;
`endif

  logic [SR_W-1:0] sr;
  logic [3:0]      cnt;
  logic [7:0]      mem [2];
  logic            rd_ptr;
  logic            wr_ptr;
  logic [1:0]      count;
  logic            overflow_q;

  logic            complete;
  logic            byte_ok;
  logic            pop;
  logic            push;
  logic [7:0]      new_byte;

  always_comb begin
    complete = bus.en && !bus.sync && (cnt == LAST);
`ifdef SEQ_SIPO_BYTE_FRAMER_PARITY_EN
    new_byte = sr;
    byte_ok  = ^{sr, bus.sin};
`else
    new_byte = {sr, bus.sin};
    byte_ok  = 1'b1;
`endif
    pop  = (count != 2'd0) && bus.out_rdy;
    // A full FIFO still accepts the byte when the head leaves in the same cycle.
    push = complete && byte_ok && ((count != 2'd2) || pop);
  end

`ifdef SEQ_SIPO_BYTE_FRAMER_PARITY_EN
  logic perr_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      perr_q <= 1'b0;
    end else if (complete && !byte_ok) begin
      perr_q <= 1'b1;
    end
  end

  assign bus.perr = perr_q;
`else
  assign bus.perr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      sr         <= '0;
      cnt        <= 4'd0;
      mem[0]     <= 8'h00;
      mem[1]     <= 8'h00;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
      overflow_q <= 1'b0;
    end else begin
      if (bus.en && bus.sync) begin
        sr  <= {{(SR_W-1){1'b0}}, bus.sin};
        cnt <= 4'd1;
      end else if (bus.en) begin
        sr  <= {sr[SR_W-2:0], bus.sin};
        cnt <= complete ? 4'd0 : cnt + 4'd1;
      end else if (bus.sync) begin
        sr  <= '0;
        cnt <= 4'd0;
      end

      if (push) begin
        mem[wr_ptr] <= new_byte;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};

      if (complete && byte_ok && (count == 2'd2) && !pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign bus.out_val  = (count != 2'd0);
  assign bus.out_byte = mem[rd_ptr];
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_seq_sipo_byte_framer.sv
// Self-checking bench for seq_sipo_byte_framer: vector table, directed corner
// sequences, then random traffic against a queue-based reference model.
module tb_seq_sipo_byte_framer;

`ifdef SEQ_SIPO_BYTE_FRAMER_PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_sipo_byte_framer_if bus ();

  seq_sipo_byte_framer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // reference model: bits of the frame in progress, queued bytes, sticky flags
  logic       part_q[$];
  logic [7:0] exp_q[$];
  logic       m_ovf;
  logic       m_perr;

  typedef struct {
    logic       en;
    logic       sin;
    logic       sync;
    logic       rdy;
    logic       e_val;
    logic [7:0] e_byte;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst_n, input logic en, input logic sin,
                            input logic sync, input logic pop);
    logic [7:0] b;
    logic       par;
    if (!rst_n) begin
      part_q.delete();
      exp_q.delete();
      m_ovf  = 1'b0;
      m_perr = 1'b0;
      return;
    end
    if (pop) void'(exp_q.pop_front());
    if (en && sync) begin
      part_q.delete();
      part_q.push_back(sin);
    end else if (en) begin
      part_q.push_back(sin);
      if (part_q.size() == FRAME) begin
        b   = 8'h00;
        par = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
          par = par ^ part_q[i];
          if (i < 8) b[7-i] = part_q[i];
        end
        part_q.delete();
        if (FRAME == 8 || par) begin
          if (exp_q.size() < 2) exp_q.push_back(b);
          else m_ovf = 1'b1;
        end else begin
          m_perr = 1'b1;
        end
      end
    end else if (sync) begin
      part_q.delete();
    end
  endtask

  // One clock: drive inputs, advance the model, compare every output.
  task automatic cycle(input logic rst_n, input logic en, input logic sin,
                       input logic sync, input logic rdy);
    logic pop;
    reset       = rst_n;
    bus.en      = en;
    bus.sin     = sin;
    bus.sync    = sync;
    bus.out_rdy = rdy;
    pop = (exp_q.size() > 0) && rdy;
    @(posedge clk);
    #1;
    model_step(rst_n, en, sin, sync, pop);
    chk("out_val", {31'd0, bus.out_val}, {31'd0, exp_q.size() > 0});
    if (exp_q.size() > 0) chk("out_byte", {24'd0, bus.out_byte}, {24'd0, exp_q[0]});
    if (!rst_n) chk("reset_byte", {24'd0, bus.out_byte}, 32'd0);
    chk("overflow", {31'd0, bus.overflow}, {31'd0, m_ovf});
    chk("perr", {31'd0, bus.perr}, {31'd0, m_perr});
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input logic par_ok, input int i);
    if (i < 8) return b[7-i];
    return par_ok ? ~^b : ^b;
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic par_ok, input logic rdy_body,
                            input logic rdy_last, input logic gaps, input logic sync_first);
    for (int i = 0; i < FRAME; i++) begin
      if (gaps) begin
        cycle(1'b1, 1'b0, i[0], 1'b0, rdy_body);
        cycle(1'b1, 1'b0, ~i[0], 1'b0, rdy_body);
      end
      cycle(1'b1, 1'b1, frame_bit(b, par_ok, i), sync_first && (i == 0),
            (i == FRAME - 1) ? rdy_last : rdy_body);
    end
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset       = 1'b0;
    bus.en      = 1'b0;
    bus.sin     = 1'b0;
    bus.sync    = 1'b0;
    bus.out_rdy = 1'b0;
    m_ovf       = 1'b0;
    m_perr      = 1'b0;

    // single byte A5 with out_rdy held high: visible for exactly one cycle
    for (int i = 0; i < FRAME; i++)
      tbl.push_back('{en: 1'b1, sin: frame_bit(8'hA5, 1'b1, i), sync: 1'b0, rdy: 1'b1,
                      e_val: (i == FRAME - 1), e_byte: 8'hA5});
    tbl.push_back('{en: 1'b0, sin: 1'b1, sync: 1'b0, rdy: 1'b1, e_val: 1'b0, e_byte: 8'h00});

    do_reset();
    chk("reset_val", {31'd0, bus.out_val}, 32'd0);
    chk("reset_ovf", {31'd0, bus.overflow}, 32'd0);
    foreach (tbl[k]) begin
      cycle(1'b1, tbl[k].en, tbl[k].sin, tbl[k].sync, tbl[k].rdy);
      chk("tbl_val", {31'd0, bus.out_val}, {31'd0, tbl[k].e_val});
      if (tbl[k].e_val) chk("tbl_byte", {24'd0, bus.out_byte}, {24'd0, tbl[k].e_byte});
    end

    // enable gaps with sin toggling: still exactly one A5
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("gap_val", {31'd0, bus.out_val}, 32'd1);
    chk("gap_byte", {24'd0, bus.out_byte}, 32'hA5);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("gap_single", {31'd0, bus.out_val}, 32'd0);
    chk("gap_ovf", {31'd0, bus.overflow}, 32'd0);

    // backpressure: third byte is dropped
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf_head", {24'd0, bus.out_byte}, 32'h11);
    chk("ovf_flag", {31'd0, bus.overflow}, 32'd1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf_pop1", {24'd0, bus.out_byte}, 32'h22);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf_empty", {31'd0, bus.out_val}, 32'd0);
    chk("ovf_sticky", {31'd0, bus.overflow}, 32'd1);

    // full FIFO with a pop on the completing edge
    do_reset();
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h33, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("fullpop_ovf", {31'd0, bus.overflow}, 32'd0);
    chk("fullpop_head", {24'd0, bus.out_byte}, 32'h22);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("fullpop_next", {24'd0, bus.out_byte}, 32'h33);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("fullpop_empty", {31'd0, bus.out_val}, 32'd0);

    // sync realignment after three garbage bits
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("sync_byte", {24'd0, bus.out_byte}, 32'hF0);
    chk("sync_val", {31'd0, bus.out_val}, 32'd1);

    // reset mid-frame with a byte queued
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, i[0], 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("midrst_val", {31'd0, bus.out_val}, 32'd0);
    chk("midrst_byte", {24'd0, bus.out_byte}, 32'h00);
    chk("midrst_ovf", {31'd0, bus.overflow}, 32'd0);

    // parity: good frame delivered, bad frame dropped with sticky perr
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("par_good_byte", {24'd0, bus.out_byte}, 32'hA5);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
`ifdef SEQ_SIPO_BYTE_FRAMER_PARITY_EN
    chk("par_bad_val", {31'd0, bus.out_val}, 32'd0);
    chk("par_bad_perr", {31'd0, bus.perr}, 32'd1);
`else
    chk("nopar_perr", {31'd0, bus.perr}, 32'd0);
`endif
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // random traffic against the reference model
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      logic rst_n, en, sync, rdy;
      rst_n = ($urandom_range(0, 399) != 0);
      en    = ($urandom_range(0, 3) != 0);
      sync  = ($urandom_range(0, 39) == 0);
      rdy   = (n < 2000) ? ($urandom_range(0, 2) == 0) : 1'b1;
      cycle(rst_n, en, $urandom_range(0, 1) == 1, sync, rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_sipo_byte_framer.md
# seq_sipo_byte_framer

Downstream consumer of the 8-bit SIPO shift register stage. It takes the same serial `en`/`sin` bit stream, counts bits into whole bytes, and queues each completed byte in a 2-entry FIFO. The FIFO drains over a val/rdy output interface. It adds frame alignment (`sync`), a sticky overflow flag and an optional parity check, which lets the serial link feed byte-oriented logic without losing data under backpressure.

## Interface
- No parameters; byte width fixed at 8, FIFO depth fixed at 2.
- clk       input   1  clock; all state updates on rising edge
- reset     input   1  synchronous, active-low reset (0 = reset, sampled on rising edge of clk)
- en        input   1  serial bit valid this cycle
- sin       input   1  serial data bit, MSB first
- sync      input   1  frame alignment: current bit (if en) starts a new byte
- out_val   output  1  FIFO non-empty, out_byte valid
- out_rdy   input   1  consumer accepts out_byte this cycle
- out_byte  output  8  FIFO head byte
- overflow  output  1  sticky: a completed byte was dropped because the FIFO was full
- perr      output  1  sticky: parity error seen (constant 0 unless parity is compiled in)

## Operation
- Shift register `sr[7:0]` and bit counter `cnt` (0..N-1). N = 8, or 9 with parity compiled in.
- When en=1 and sync=0:
  - sr <= {sr[6:0], sin}
  - cnt <= cnt+1
- When en=1 and sync=1:
  - the partial byte is discarded
  - sr <= {7'b0, sin}
  - cnt <= 1
- When en=0 and sync=1: partial byte discarded; cnt <= 0; sr <= 0.
- When en=0 and sync=0: sr and cnt hold.
- Byte completion: en=1, sync=0, cnt==7 (no parity).
  - Completed byte = {sr[6:0], sin}.
  - cnt wraps to 0.
  - A push is attempted into the FIFO.
- Pop: occurs when out_val && out_rdy.
- FIFO is 2 entries, in-order, head drives out_byte.
- Push while FIFO full:
  - With a simultaneous pop: the push is accepted, count stays 2.
  - Without a pop: the byte is dropped and overflow <= 1.
- Push into an empty FIFO with out_rdy=1: no bypass. The byte appears on out_val the next cycle.
- Pop from an empty FIFO is impossible, because out_val=0.
- overflow and perr clear only on reset.
- out_byte when empty is don't-care for checking, but must be driven with no X; the implementation holds the last head value or 0.

## Timing
- Reset (reset=0 at a rising edge) sets:
  - cnt=0, sr=0
  - FIFO empty
  - out_val=0, out_byte=8'h00
  - overflow=0, perr=0
- Reset mid-frame discards the partial byte and all queued bytes.
- Latency:
  - The 8th bit is sampled at edge k, and out_val=1 with the byte from edge k onward, visible in cycle k+1.
  - Minimum 9 cycles from the first bit to out_val.
- Outputs are registered state only. There is no combinational path from en/sin/sync/out_rdy to any output.
- out_val/out_byte stay stable while out_val=1 and out_rdy=0.
- Throughput: 1 byte per 8 enabled cycles. A consumer holding out_rdy=1 never causes overflow.

## Configuration
- Macro: SEQ_SIPO_BYTE_FRAMER_PARITY_EN.
- Defined:
  - Frame is 9 bits: 8 data bits, MSB first, then 1 odd-parity bit.
  - Completion occurs at cnt==8; data = sr, and the parity bit = sin.
  - If ^{sr, sin} == 1, the byte is pushed (same full/overflow rules).
  - Otherwise the byte is discarded, perr <= 1 (sticky), and no push occurs.
- Undefined:
  - Frame is 8 bits.
  - perr is tied to 0.
  - No parity logic is present.

## Test plan
- Single byte: reset, then 8 enabled bits 1,0,1,0,0,1,0,1 with out_rdy=1 → out_val=1 for exactly one cycle with out_byte=8'hA5. No output before the 9th cycle.
- Enable gaps: same 8 bits as the single-byte case, with en=0 cycles interleaved (sin toggling on those cycles) → still exactly one byte 8'hA5, overflow=0.
- Backpressure/overflow:
  - out_rdy=0; send 8'h11, 8'h22, 8'h33 → out_val=1, out_byte=8'h11, overflow=1 after the third byte completes.
  - Then raise out_rdy → pops 8'h11, then 8'h22, then out_val=0.
- Full with simultaneous pop: FIFO holds 8'h11, 8'h22; assert out_rdy in the same cycle the byte 8'h33 completes → overflow stays 0; subsequent pops return 8'h22 then 8'h33.
- Sync realign and reset:
  - Send 3 bits of garbage, then sync=1/en=1 with bits 1,1,1,1,0,0,0,0 → byte 8'hF0.
  - Pull reset low mid-frame with one byte queued → out_val=0, overflow=0, out_byte=8'h00 next cycle.
- Parity (macro defined):
  - 8'hA5 + parity 1 → byte delivered.
  - 8'hA5 + parity 0 → no byte, perr=1 sticky.
  - Macro undefined → perr=0 for all of the above.
